bus_master_if: RTL and testbench

- Requester-side counterpart of the 4-master bus arbiter.
- One instance sits between each bus master (CPU IF stage, CPU MEM stage, and so on) and the shared bus.
- Converts a single-cycle access request from the pipeline into the full bus transaction:
  - request the bus (`bus_req_`);
  - wait for the grant (`bus_grnt_`);
  - strobe the address (`bus_as_`);
  - wait for the slave to be ready (`bus_rdy_`);
  - hand the read data back and release the bus.
- Stalls the pipeline through `busy` while a transaction is in flight.

---
 rtl/bus_master_if_pkg.sv | 27 ++
 rtl/bus_master_if_if.sv | 29 ++
 rtl/bus_master_if.sv | 128 ++++++++++++
 tb/tb_bus_master_if.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_if_pkg.sv
// bus_master_if_pkg
//   Shared definitions for the bus master interface: bus-interface state
//   encoding, read/write encoding, active-low enable levels, reset level
//   and the default word address/data widths.
package bus_master_if_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  // Active-low control levels used on the bus handshake.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Level of the reset input that holds the design in reset.
  localparam logic RESET_ENABLE = 1'b0;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    BUS_IF_STATE_IDLE   = 2'd0,
    BUS_IF_STATE_REQ    = 2'd1,
    BUS_IF_STATE_ACCESS = 2'd2,
    BUS_IF_STATE_WAIT   = 2'd3
  } bus_if_state_e;

endpackage

// File: rtl/bus_master_if_if.sv
// bus_master_if_if
//   Shared-bus signal bundle between one bus master interface and the
//   arbiter/slave side.
//   master modport: drives bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data;
//                   receives bus_grnt_, bus_rd_data, bus_rdy_.
//   slave modport:  the opposite directions.
interface bus_master_if_if #(
  parameter int ADDR_W = bus_master_if_pkg::WORD_ADDR_W,
  parameter int DATA_W = bus_master_if_pkg::WORD_DATA_W
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/bus_master_if.sv
// bus_master_if
//   Requester-side bus interface. Turns a one-cycle access strobe from the
//   pipeline into a full bus transaction (request, grant, address strobe,
//   slave ready) and returns read data, stalling the pipeline via busy.
//
//   state   | meaning
//   IDLE    | no transaction; accepts a new access when as_=0 and flush=0
//   REQ     | bus requested, waiting for the arbiter grant
//   ACCESS  | address strobed (first cycle only), waiting for slave ready
//   WAIT    | transaction done; read data presented until stall drops
//
//   Ports:
//     clk, reset       clock, asynchronous active-low reset
//     stall, flush     pipeline stall / flush
//     addr, as_, rw,   pipeline access request
//     wr_data
//     rd_data, busy    read data and stall request back to the pipeline
//     bus              shared-bus signals (master modport)
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W = WORD_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               as_,
  input  logic               rw,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  bus_master_if_if.master    bus
);

  bus_if_state_e     state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_as_q, bus_as_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_rw_q, bus_rw_d;
  logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state_q       <= BUS_IF_STATE_IDLE;
      bus_req_q     <= DISABLE_;
      bus_as_q      <= DISABLE_;
      bus_addr_q    <= '0;
      bus_rw_q      <= READ;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_addr_q    <= bus_addr_d;
      bus_rw_q      <= bus_rw_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_addr_d    = bus_addr_q;
    bus_rw_d      = bus_rw_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    busy          = 1'b0;
    rd_data       = '0;

    case (state_q)
      BUS_IF_STATE_IDLE: begin
        bus_req_d = DISABLE_;
        if ((as_ == ENABLE_) && !flush) begin
          bus_addr_d    = addr;
          bus_rw_d      = rw;
          bus_wr_data_d = wr_data;
          bus_req_d     = ENABLE_;
          state_d       = BUS_IF_STATE_REQ;
          busy          = 1'b1;
        end
      end
      BUS_IF_STATE_REQ: begin
        busy      = 1'b1;
        bus_req_d = ENABLE_;
        // Strobe is registered, so it is low for exactly the first ACCESS cycle.
        if (bus.bus_grnt_ == ENABLE_) begin
          bus_as_d = ENABLE_;
          state_d  = BUS_IF_STATE_ACCESS;
        end
      end
      BUS_IF_STATE_ACCESS: begin
        busy     = 1'b1;
        bus_as_d = DISABLE_;
        if (bus.bus_rdy_ == ENABLE_) begin
          bus_req_d = DISABLE_;
          // Writes leave rd_buf alone, so WAIT replays the last read value.
          if (bus_rw_q == READ) begin
            rd_buf_d = bus.bus_rd_data;
          end
          state_d = BUS_IF_STATE_WAIT;
        end
      end
      BUS_IF_STATE_WAIT: begin
        rd_data = rd_buf_q;
        if (!stall) begin
          state_d = BUS_IF_STATE_IDLE;
        end
      end
      default: begin
        state_d = BUS_IF_STATE_IDLE;
      end
    endcase
  end

  assign bus.bus_req_    = bus_req_q;
  assign bus.bus_as_     = bus_as_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_rw      = bus_rw_q;
  assign bus.bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if
//   Directed testbench for bus_master_if. The bench plays arbiter and slave
//   by driving grant/ready/read data directly, cycle by cycle.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] addr;
  logic        as_;
  logic        rw;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int req_low  = 0;
  int as_low   = 0;

  bus_master_if_if #(.ADDR_W(30), .DATA_W(32)) bif ();

  bus_master_if #(.ADDR_W(30), .DATA_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .flush   (flush),
    .addr    (addr),
    .as_     (as_),
    .rw      (rw),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .busy    (busy),
    .bus     (bif.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arbiter protocol: once a request has been granted, the grant must stay
  // while the request is held.
  logic prev_req_  = 1'b1;
  logic prev_grnt_ = 1'b1;
  always @(posedge clk) begin
    #2;
    if (prev_req_ === 1'b0 && prev_grnt_ === 1'b0 && bif.bus_req_ === 1'b0) begin
      checks++;
      assert (bif.bus_grnt_ === 1'b0) else begin
        failures++;
        $error("FAIL grant_held observed=%b expected=0", bif.bus_grnt_);
      end
    end
    prev_req_  = bif.bus_req_;
    prev_grnt_ = bif.bus_grnt_;
  end

  initial begin
    reset           = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    addr            = '0;
    as_             = 1'b1;
    rw              = 1'b1;
    wr_data         = '0;
    bif.bus_grnt_   = 1'b1;
    bif.bus_rdy_    = 1'b1;
    bif.bus_rd_data = '0;

    // Reset values
    tick();
    tick();
    chk("rst_req", 32'(bif.bus_req_), 32'd1);
    chk("rst_as", 32'(bif.bus_as_), 32'd1);
    chk("rst_addr", 32'(bif.bus_addr), 32'd0);
    chk("rst_rw", 32'(bif.bus_rw), 32'd1);
    chk("rst_wdata", bif.bus_wr_data, 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(BUS_IF_STATE_IDLE));
    reset = 1'b1;
    tick();

    // 1: read, immediate grant and ready
    addr = 30'h0000100; rw = 1'b1; as_ = 1'b0;
    #1 chk("t1_busy_idle", 32'(busy), 32'd1);
    tick();
    as_ = 1'b1; addr = '0;
    chk("t1_state_req", 32'(dut.state_q), 32'(BUS_IF_STATE_REQ));
    chk("t1_req_low", 32'(bif.bus_req_), 32'd0);
    chk("t1_as_high_req", 32'(bif.bus_as_), 32'd1);
    chk("t1_addr", 32'(bif.bus_addr), 32'h0000100);
    chk("t1_rw", 32'(bif.bus_rw), 32'd1);
    chk("t1_busy_req", 32'(busy), 32'd1);
    bif.bus_grnt_ = 1'b0;
    tick();
    chk("t1_state_acc", 32'(dut.state_q), 32'(BUS_IF_STATE_ACCESS));
    chk("t1_as_low", 32'(bif.bus_as_), 32'd0);
    chk("t1_req_low_acc", 32'(bif.bus_req_), 32'd0);
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hDEADBEEF;
    tick();
    chk("t1_state_wait", 32'(dut.state_q), 32'(BUS_IF_STATE_WAIT));
    chk("t1_as_released", 32'(bif.bus_as_), 32'd1);
    chk("t1_req_released", 32'(bif.bus_req_), 32'd1);
    chk("t1_rdata", rd_data, 32'hDEADBEEF);
    chk("t1_busy_wait", 32'(busy), 32'd0);
    bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1; bif.bus_rd_data = 32'h0;
    tick();
    chk("t1_state_idle", 32'(dut.state_q), 32'(BUS_IF_STATE_IDLE));
    chk("t1_rdata_idle", rd_data, 32'd0);

    // 2: write, grant after 3 cycles, slave ready after 2 wait cycles
    addr = 30'h000002A; rw = 1'b0; wr_data = 32'h12345678; as_ = 1'b0;
    req_low = 0; as_low = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      as_ = 1'b1; wr_data = 32'hFFFFFFFF; rw = 1'b1;
      if (bif.bus_req_ === 1'b0) req_low++;
      if (bif.bus_as_ === 1'b0) as_low++;
      chk("t2_wdata", bif.bus_wr_data, 32'h12345678);
      chk("t2_rw", 32'(bif.bus_rw), 32'd0);
      #1 chk("t2_busy", 32'(busy), 32'd1);
      bif.bus_grnt_ = (i >= 3) ? 1'b0 : 1'b1;
      bif.bus_rdy_  = (i == 6) ? 1'b0 : 1'b1;
      bif.bus_rd_data = 32'h11111111;
    end
    tick();
    chk("t2_req_low_cycles", 32'(req_low), 32'd7);
    chk("t2_as_low_cycles", 32'(as_low), 32'd1);
    chk("t2_state_wait", 32'(dut.state_q), 32'(BUS_IF_STATE_WAIT));
    chk("t2_req_released", 32'(bif.bus_req_), 32'd1);
    chk("t2_rdata_prev", rd_data, 32'hDEADBEEF);
    chk("t2_busy_wait", 32'(busy), 32'd0);
    bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;

    // 3: stall held in WAIT for 4 cycles with a pending request
    stall = 1'b1; as_ = 1'b0; addr = 30'h0000033; rw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_state_wait", 32'(dut.state_q), 32'(BUS_IF_STATE_WAIT));
      chk("t3_rdata_held", rd_data, 32'hDEADBEEF);
      chk("t3_no_req", 32'(bif.bus_req_), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);
    end
    stall = 1'b0; as_ = 1'b1;
    tick();
    chk("t3_state_idle", 32'(dut.state_q), 32'(BUS_IF_STATE_IDLE));
    chk("t3_req_idle", 32'(bif.bus_req_), 32'd1);

    // 4: flush with as_ in IDLE, then flush during ACCESS
    flush = 1'b1; as_ = 1'b0;
    #1 chk("t4_busy_flush", 32'(busy), 32'd0);
    tick();
    chk("t4_req_flush", 32'(bif.bus_req_), 32'd1);
    chk("t4_state_flush", 32'(dut.state_q), 32'(BUS_IF_STATE_IDLE));
    flush = 1'b0; addr = 30'h000003C; rw = 1'b1;
    tick();
    as_ = 1'b1;
    chk("t4_state_req", 32'(dut.state_q), 32'(BUS_IF_STATE_REQ));
    bif.bus_grnt_ = 1'b0;
    tick();
    flush = 1'b1; bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hCAFEF00D;
    #1 chk("t4_busy_acc_flush", 32'(busy), 32'd1);
    tick();
    chk("t4_state_wait", 32'(dut.state_q), 32'(BUS_IF_STATE_WAIT));
    chk("t4_rdata", rd_data, 32'hCAFEF00D);
    flush = 1'b0; bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;
    tick();

    // 5: reset pulse while in ACCESS, then a clean read
    as_ = 1'b0; addr = 30'h0000055; rw = 1'b1;
    tick();
    as_ = 1'b1;
    bif.bus_grnt_ = 1'b0;
    tick();
    chk("t5_state_acc", 32'(dut.state_q), 32'(BUS_IF_STATE_ACCESS));
    #1 reset = 1'b0;
    #1;
    chk("t5_req_async", 32'(bif.bus_req_), 32'd1);
    chk("t5_as_async", 32'(bif.bus_as_), 32'd1);
    chk("t5_addr_async", 32'(bif.bus_addr), 32'd0);
    chk("t5_state_async", 32'(dut.state_q), 32'(BUS_IF_STATE_IDLE));
    chk("t5_rdata_async", rd_data, 32'd0);
    bif.bus_grnt_ = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    as_ = 1'b0; addr = 30'h0000077;
    tick();
    as_ = 1'b1;
    chk("t5_addr_after", 32'(bif.bus_addr), 32'h0000077);
    bif.bus_grnt_ = 1'b0;
    tick();
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'h0BADCAFE;
    tick();
    chk("t5_rdata_after", rd_data, 32'h0BADCAFE);
    bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;
    tick();

    // 6: back-to-back reads
    as_ = 1'b0; addr = 30'h0000001;
    tick();
    as_ = 1'b1;
    bif.bus_grnt_ = 1'b0;
    tick();
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hA5A5A5A5;
    tick();
    chk("t6_rdata_a", rd_data, 32'hA5A5A5A5);
    chk("t6_req_rel_a", 32'(bif.bus_req_), 32'd1);
    bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;
    as_ = 1'b0; addr = 30'h0000002;
    #1 chk("t6_busy_wait", 32'(busy), 32'd0);
    tick();
    chk("t6_state_gap", 32'(dut.state_q), 32'(BUS_IF_STATE_IDLE));
    chk("t6_req_gap", 32'(bif.bus_req_), 32'd1);
    chk("t6_busy_gap", 32'(busy), 32'd1);
    tick();
    as_ = 1'b1;
    chk("t6_addr_b", 32'(bif.bus_addr), 32'h0000002);
    chk("t6_req_b", 32'(bif.bus_req_), 32'd0);
    bif.bus_grnt_ = 1'b0;
    tick();
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'h5A5A5A5A;
    tick();
    chk("t6_rdata_b", rd_data, 32'h5A5A5A5A);
    bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;
    tick();
    chk("t6_state_end", 32'(dut.state_q), 32'(BUS_IF_STATE_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
